// File: rtl/x_load_sequencer_pkg.sv
// Shared encodings and defaults for the X-operand load sequencer.
package x_load_sequencer_pkg;

  localparam int unsigned X_COL_W  = 3;
  localparam int unsigned X_DATA_W = 32;
  localparam int unsigned X_ADDR_W = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ     = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_PRESENT = 3'd3;
  localparam logic [2:0] ST_COL_END = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_REQ     = ST_REQ,
    S_WAIT    = ST_WAIT,
    S_PRESENT = ST_PRESENT,
    S_COL_END = ST_COL_END,
    S_DONE    = ST_DONE
  } x_state_e;

  // Words to load in a given column: first column is wide, last column loads nothing.
  function automatic int unsigned col_quota(input int unsigned col, input int unsigned n_cols,
                                            input int unsigned first, input int unsigned next);
    if (col == 0) return first;
    if (col == n_cols - 1) return 0;
    return next;
  endfunction

endpackage

// File: rtl/x_load_sequencer_hold.sv
// ROM latency pipe plus holding register; presents captured words with valid/ready.
module x_load_sequencer_hold
  import x_load_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W  = X_DATA_W,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [DATA_W-1:0] rom_data_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              capture_o
);

  logic [ROM_LAT-1:0] pipe_q, pipe_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;

  always_comb begin
    pipe_d  = ROM_LAT'({pipe_q, req_i});
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && ready_i) valid_d = 1'b0;
    // Last pipe stage marks the cycle the ROM drives data for the issued read
    if (pipe_q[ROM_LAT-1]) begin
      data_d  = rom_data_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pipe_q  <= pipe_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign capture_o = pipe_q[ROM_LAT-1];

endmodule

// File: rtl/x_load_sequencer.sv
// Walks X words out of the ROM and hands them to the X buffer column by column.
module x_load_sequencer
  import x_load_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W      = X_ADDR_W,
  parameter int unsigned DATA_W      = X_DATA_W,
  parameter int unsigned N_COLS      = 8,
  parameter int unsigned N_ROWS      = 4,
  parameter int unsigned WORDS_FIRST = 3,
  parameter int unsigned WORDS_NEXT  = 1,
  parameter int unsigned ROM_LAT     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [ADDR_W-1:0]  base_addr_i,
  output logic               rom_en_o,
  output logic [ADDR_W-1:0]  rom_addr_o,
  input  logic [DATA_W-1:0]  rom_data_i,
  output logic [DATA_W-1:0]  x_load_o,
  output logic               valid_input_o,
  input  logic               load_en_i,
  output logic [X_COL_W-1:0] col_counter_o,
  input  logic               col_step_i,
  output logic               busy_o,
  output logic               done_o
);

  localparam int unsigned ROW_W  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int unsigned WCNT_W = $clog2(WORDS_FIRST + 1);

  x_state_e           state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d, rom_addr_q, rom_addr_d;
  logic [X_COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d, wcnt_inc;
  logic               rom_en_q, rom_en_d, busy_q, busy_d, done_q, done_d;
  logic               capture, xfer_c;

  function automatic logic [WCNT_W-1:0] quota_of(input logic [X_COL_W-1:0] c);
    return WCNT_W'(col_quota(32'(c), N_COLS, WORDS_FIRST, WORDS_NEXT));
  endfunction

  x_load_sequencer_hold #(.DATA_W(DATA_W), .ROM_LAT(ROM_LAT)) u_hold (
    .clk        (clk),
    .rst        (rst),
    .req_i      (rom_en_q),
    .rom_data_i (rom_data_i),
    .ready_i    (load_en_i),
    .data_o     (x_load_o),
    .valid_o    (valid_input_o),
    .capture_o  (capture)
  );

  assign xfer_c   = valid_input_o & load_en_i;
  assign wcnt_inc = wcnt_q + WCNT_W'(1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    col_d   = col_q;
    row_d   = row_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      S_IDLE: if (start_i) begin
        addr_d  = base_addr_i;
        col_d   = '0;
        row_d   = '0;
        wcnt_d  = '0;
        state_d = S_REQ;
      end
      S_REQ: begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = S_WAIT;
      end
      S_WAIT: if (capture) state_d = S_PRESENT;
      S_PRESENT: if (xfer_c) begin
        wcnt_d  = wcnt_inc;
        state_d = (wcnt_inc == quota_of(col_q)) ? S_COL_END : S_REQ;
      end
      // A transfer never coexists with COL_END, so col_step here is always a real advance
      S_COL_END: if (col_step_i) begin
        wcnt_d = '0;
        col_d  = col_q + X_COL_W'(1);
        if (col_q == X_COL_W'(N_COLS - 1)) begin
          col_d = '0;
          row_d = row_q + ROW_W'(1);
        end
        if (col_q == X_COL_W'(N_COLS - 1) && row_q == ROW_W'(N_ROWS - 1)) begin
          row_d   = '0;
          state_d = S_DONE;
        end else begin
          state_d = (quota_of(col_d) == '0) ? S_COL_END : S_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    rom_en_d   = (state_d == S_REQ);
    rom_addr_d = rom_en_d ? addr_d : rom_addr_q;
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      wcnt_q     <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      col_q      <= col_d;
      row_q      <= row_d;
      wcnt_q     <= wcnt_d;
      rom_en_q   <= rom_en_d;
      rom_addr_q <= rom_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rom_en_o      = rom_en_q;
  assign rom_addr_o    = rom_addr_q;
  assign col_counter_o = col_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_x_load_sequencer.sv
// Directed bench: cycle table for the first columns, then a scored full job and corner sequences.
`timescale 1ns/1ps
module tb_x_load_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0, load_en = 1'b0, col_step = 1'b0;
  logic [7:0]  base_addr = 8'h00;
  logic        rom_en, valid, busy, done;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data, x_load;
  logic [2:0]  col;

  logic        start2 = 1'b0, load_en2 = 1'b1, col_step2 = 1'b0;
  logic [7:0]  base_addr2 = 8'h00;
  logic        rom_en2, valid2, busy2, done2;
  logic [7:0]  rom_addr2;
  logic [31:0] rom_data2, x_load2, r3_s0, r3_s1;
  logic [2:0]  col2;

  x_load_sequencer dut (
    .clk(clk), .rst(rst), .start_i(start), .base_addr_i(base_addr),
    .rom_en_o(rom_en), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .x_load_o(x_load), .valid_input_o(valid), .load_en_i(load_en),
    .col_counter_o(col), .col_step_i(col_step), .busy_o(busy), .done_o(done)
  );

  x_load_sequencer #(.ROM_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start_i(start2), .base_addr_i(base_addr2),
    .rom_en_o(rom_en2), .rom_addr_o(rom_addr2), .rom_data_i(rom_data2),
    .x_load_o(x_load2), .valid_input_o(valid2), .load_en_i(load_en2),
    .col_counter_o(col2), .col_step_i(col_step2), .busy_o(busy2), .done_o(done2)
  );

  function automatic logic [31:0] rom_word(input logic [7:0] a);
    return {8'hC3, a, ~a, a ^ 8'h5A};
  endfunction

  // ROM models: garbage when not reading, so a mistimed capture is visible
  always @(posedge clk) rom_data <= rom_en ? rom_word(rom_addr) : 32'hBAD0_0001;
  always @(posedge clk) begin
    r3_s0     <= rom_en2 ? rom_word(rom_addr2) : 32'hBAD0_0003;
    r3_s1     <= r3_s0;
    rom_data2 <= r3_s1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        st, le, cs;
    logic        ren;
    logic [7:0]  addr;
    logic        v;
    logic [31:0] x;
    logic [2:0]  c;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic le, input logic cs, input logic ren,
                              input logic [7:0] a, input logic v, input logic [31:0] x,
                              input logic [2:0] c);
    vec_t r;
    r.st = st; r.le = le; r.cs = cs; r.ren = ren; r.addr = a; r.v = v; r.x = x; r.c = c;
    return r;
  endfunction

  vec_t        tbl[18];
  logic [7:0]  exp_addr, last_addr;
  logic [31:0] x_hold;
  int          bp_left, idx, w, exp_col;
  bit          bp_started, finished;

  initial begin
    tbl[0]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 8'h10, 1'b0, 32'h0, 3'd0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 3'd0);
    tbl[2]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, rom_word(8'h10), 3'd0);
    tbl[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, rom_word(8'h10), 3'd0);
    tbl[4]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 32'h0, 3'd0);
    tbl[5]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 3'd0);
    tbl[6]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, rom_word(8'h11), 3'd0);
    tbl[7]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, rom_word(8'h11), 3'd0);
    tbl[8]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 8'h12, 1'b0, 32'h0, 3'd0);
    tbl[9]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 3'd0);
    tbl[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, rom_word(8'h12), 3'd0);
    tbl[11] = mk(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 3'd0);
    tbl[12] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 3'd0);
    tbl[13] = mk(1'b0, 1'b1, 1'b1, 1'b1, 8'h13, 1'b0, 32'h0, 3'd1);
    tbl[14] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 3'd1);
    tbl[15] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, rom_word(8'h13), 3'd1);
    tbl[16] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 3'd1);
    tbl[17] = mk(1'b0, 1'b1, 1'b1, 1'b1, 8'h14, 1'b0, 32'h0, 3'd2);

    // Reset state
    repeat (2) step();
    check("reset_outputs", 64'({rom_en, rom_addr, x_load, valid, col, busy, done}), 64'(0));
    @(negedge clk) rst = 1'b1;
    step();

    // Cycle table: first word latency, backpressure, early and simultaneous col_step
    base_addr = 8'h10;
    for (int i = 0; i < 18; i++) begin
      start = tbl[i].st; load_en = tbl[i].le; col_step = tbl[i].cs;
      step();
      check($sformatf("vec%0d", i),
            64'({rom_en, tbl[i].ren ? rom_addr : 8'h00, valid, tbl[i].v ? x_load : 32'h0, col, busy, done}),
            64'({tbl[i].ren, tbl[i].addr, tbl[i].v, tbl[i].x, tbl[i].c, 1'b1, 1'b0}));
    end

    // Remainder of the job, scored against the address/column model
    exp_addr = 8'h15; last_addr = 8'h14; bp_left = 0; bp_started = 0; finished = 0;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      start     = (cyc == 30);
      base_addr = (cyc == 30) ? 8'hF0 : 8'h10;
      col_step  = (cyc % 3 == 1);
      load_en   = (bp_left == 0);
      step();
      if (bp_left > 0) begin
        check("bp_valid", 64'(valid), 64'(1));
        check("bp_x_stable", 64'(x_load), 64'(x_hold));
        check("bp_no_rom_en", 64'(rom_en), 64'(0));
        bp_left--;
      end
      if (rom_en) begin
        check("rom_addr", 64'(rom_addr), 64'(exp_addr));
        idx = int'(rom_addr) - 16;
        w = idx % 9;
        exp_col = (w < 3) ? 0 : w - 2;
        check("req_col", 64'(col), 64'(exp_col));
        last_addr = rom_addr;
        exp_addr  = exp_addr + 8'h01;
      end
      if (valid) begin
        check("x_load", 64'(x_load), 64'(rom_word(last_addr)));
        if (!bp_started && last_addr == 8'h20) begin
          bp_started = 1; bp_left = 5; x_hold = x_load;
        end
      end
      if (done) begin
        check("busy_in_done", 64'(busy), 64'(1));
        check("end_addr", 64'(exp_addr), 64'(8'h34));
        finished = 1;
      end
    end
    if (!finished) check("job_timeout", 64'(finished), 64'(1));
    start = 1'b0; col_step = 1'b0; load_en = 1'b1;
    step();
    check("done_single_pulse", 64'({done, busy}), 64'(0));

    // Reset during WAIT, then a fresh job
    base_addr = 8'h80; start = 1'b1;
    step();
    start = 1'b0;
    check("pre_reset_req", 64'({rom_en, rom_addr}), 64'({1'b1, 8'h80}));
    step();
    #2 rst = 1'b0;
    #1;
    check("midjob_reset", 64'({rom_en, rom_addr, x_load, valid, col, busy, done}), 64'(0));
    @(negedge clk) rst = 1'b1;
    step();
    check("post_reset_idle", 64'({valid, busy}), 64'(0));
    base_addr = 8'h40; start = 1'b1;
    step();
    start = 1'b0;
    check("restart_req", 64'({rom_en, rom_addr, busy}), 64'({1'b1, 8'h40, 1'b1}));
    step();
    check("restart_wait", 64'(valid), 64'(0));
    step();
    check("restart_present", 64'({valid, x_load}), 64'({1'b1, rom_word(8'h40)}));

    // ROM_LAT=3 instance: valid four cycles after rom_en
    base_addr2 = 8'h77; start2 = 1'b1;
    step();
    start2 = 1'b0;
    check("lat3_req", 64'({rom_en2, rom_addr2}), 64'({1'b1, 8'h77}));
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("lat3_valid_k%0d", k), 64'(valid2), 64'(k == 4));
    end
    check("lat3_x_load", 64'(x_load2), 64'(rom_word(8'h77)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
